// File: rtl/dl_tx_scheduler.sv
// dl_tx_scheduler: drains the transaction layer's four output FIFOs round-robin,
// one word per frame, tags each word with channel, sequence number and parity,
// and hands the frame to the data-link transmitter over valid/ready.
// Optional feature macro: LINK_PARITY_EN (frame MSB = even parity of lower bits;
// tied to 0 when undefined).
//
// state | meaning
// IDLE  | waiting for active and a non-empty FIFO; picks the next grant
// POP   | one-cycle pop strobe to the granted FIFO
// CAPT  | FIFO read data valid; frame is built and loaded
// SEND  | frame presented; held until link_ready
module dl_tx_scheduler #(
  parameter int WORD_SIZE  = 10,
  parameter int SEQ_W      = 4,
  parameter int FIFO_UNITS = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         active,
  input  logic [FIFO_UNITS-1:0]        fifo_empty,
  input  logic [WORD_SIZE-1:0]         fifo_data0,
  input  logic [WORD_SIZE-1:0]         fifo_data1,
  input  logic [WORD_SIZE-1:0]         fifo_data2,
  input  logic [WORD_SIZE-1:0]         fifo_data3,
  input  logic                         link_ready,
  output logic [FIFO_UNITS-1:0]        fifo_rd,
  output logic [WORD_SIZE+SEQ_W+2:0]   tx_frame,
  output logic                         tx_valid,
  output logic [7:0]                   frame_cnt,
  output logic                         busy
);

  localparam int CH_W = $clog2(FIFO_UNITS);

  typedef enum logic [1:0] {IDLE, POP, CAPT, SEND} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     grant, last_grant, pick_ch, cand;
  logic                pick_found;
  logic [SEQ_W-1:0]    seq;
  logic [WORD_SIZE-1:0] data_sel;
  logic                parity;

  // Round-robin search: first non-empty channel starting after the last grant.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int i = 1; i <= FIFO_UNITS; i++) begin
      cand = last_grant + CH_W'(i);
      if (!pick_found && !fifo_empty[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  // Read-data mux for the granted channel.
  always_comb begin
    case (grant)
      CH_W'(0): data_sel = fifo_data0;
      CH_W'(1): data_sel = fifo_data1;
      CH_W'(2): data_sel = fifo_data2;
      default:  data_sel = fifo_data3;
    endcase
  end

  // Frame parity bit, formed from the same fields loaded at CAPT.
  always_comb begin
`ifdef LINK_PARITY_EN
    parity = ^{seq, grant, data_sel};
`else
    parity = 1'b0;
`endif
  end

  // Next-state logic and the one-hot pop strobe.
  always_comb begin
    state_nxt = state;
    fifo_rd   = '0;
    case (state)
      IDLE: if (active && pick_found) state_nxt = POP;
      POP: begin
        fifo_rd   = {{(FIFO_UNITS-1){1'b0}}, 1'b1} << grant;
        state_nxt = CAPT;
      end
      CAPT: state_nxt = SEND;
      SEND: if (link_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_valid = (state == SEND);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant, frame, sequence and counters; last_grant resets to the top channel
  // so the first search after reset starts at channel 0.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant      <= '0;
      last_grant <= '1;
      seq        <= '0;
      tx_frame   <= '0;
      frame_cnt  <= '0;
    end else begin
      if (state == IDLE && active && pick_found) grant <= pick_ch;
      if (state == CAPT) tx_frame <= {parity, seq, grant, data_sel};
      if (state == SEND && link_ready) begin
        seq        <= seq + SEQ_W'(1);
        frame_cnt  <= frame_cnt + 8'd1;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_dl_tx_scheduler.sv
// Bench for dl_tx_scheduler: FIFO model, expected-frame scoreboard, directed steps.
module tb_dl_tx_scheduler;

  localparam int WS = 10;
  localparam int SW = 4;
  typedef logic [WS-1:0]      word_t;
  typedef logic [WS+SW+2:0]   frame_t;

  logic       clk = 1'b0;
  logic       reset_L, active, link_ready;
  logic [3:0] fifo_empty, fifo_rd;
  word_t      fifo_data0, fifo_data1, fifo_data2, fifo_data3;
  frame_t     tx_frame;
  logic       tx_valid, busy;
  logic [7:0] frame_cnt;

  word_t  mem [4][64];
  int     wr_ptr [4] = '{default: 0};
  int     rd_ptr [4] = '{default: 0};
  word_t  fd [4]     = '{default: '0};
  logic   underflow  = 1'b0;

  frame_t     exp_q[$];
  frame_t     held, got;
  logic [SW-1:0] exp_seq;
  int         total, bad, n;
  logic       prev_valid;
  frame_t     prev_frame;

  always #5 clk = ~clk;

  dl_tx_scheduler #(.WORD_SIZE(WS), .SEQ_W(SW), .FIFO_UNITS(4)) dut (
    .clk(clk), .reset_L(reset_L), .active(active), .fifo_empty(fifo_empty),
    .fifo_data0(fifo_data0), .fifo_data1(fifo_data1), .fifo_data2(fifo_data2),
    .fifo_data3(fifo_data3), .link_ready(link_ready), .fifo_rd(fifo_rd),
    .tx_frame(tx_frame), .tx_valid(tx_valid), .frame_cnt(frame_cnt), .busy(busy)
  );

  assign fifo_data0 = fd[0];
  assign fifo_data1 = fd[1];
  assign fifo_data2 = fd[2];
  assign fifo_data3 = fd[3];

  always_comb begin
    fifo_empty = '1;
    for (int i = 0; i < 4; i++) fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
  end

  // FIFO model: registered read, data valid the cycle after the pop.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd[i]) begin
        if (wr_ptr[i] == rd_ptr[i]) underflow <= 1'b1;
        else begin
          fd[i]     <= mem[i][rd_ptr[i] % 64];
          rd_ptr[i] <= rd_ptr[i] + 1;
        end
      end
    end
  end

  function automatic frame_t mk(logic [SW-1:0] s, logic [1:0] ch, word_t d);
    logic p;
    p = 1'b0;
`ifdef LINK_PARITY_EN
    p = ^{s, ch, d};
`endif
    return {p, s, ch, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int ch, input word_t d, input logic expect_it);
    mem[ch][wr_ptr[ch] % 64] = d;
    wr_ptr[ch] = wr_ptr[ch] + 1;
    if (expect_it) begin
      exp_q.push_back(mk(exp_seq, 2'(ch), d));
      exp_seq = exp_seq + 1'b1;
    end
  endtask

  // Advance to the next falling edge; a frame that was valid at the previous
  // falling edge with link_ready held through the rising edge was handed off.
  task automatic step();
    @(negedge clk);
    if (prev_valid && link_ready && reset_L) begin
      chk("sb_has_entry", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("sb_frame", prev_frame, got);
      end
    end
    if (fifo_rd != 4'b0) chk("rd_onehot", 32'($onehot(fifo_rd)), 1);
    prev_valid = tx_valid;
    prev_frame = tx_frame;
  endtask

  task automatic run_until_cnt(input logic [7:0] target, input int limit, output int cnt);
    cnt = 0;
    while (frame_cnt !== target && cnt < limit) begin
      step();
      cnt++;
    end
    chk("cnt_reach", frame_cnt, target);
  endtask

  task automatic wait_valid(input int limit);
    int k;
    k = 0;
    while (tx_valid !== 1'b1 && k < limit) begin
      step();
      k++;
    end
    chk("valid_reach", tx_valid, 1);
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    active  = 1'b0;
    step();
    step();
    reset_L = 1'b1;
    exp_seq = '0;
    step();
  endtask

  initial begin
    total = 0; bad = 0; exp_seq = '0;
    prev_valid = 1'b0; prev_frame = '0;
    reset_L = 1'b0; active = 1'b0; link_ready = 1'b0;
    repeat (3) step();
    chk("rst_rd", fifo_rd, 0);
    chk("rst_frame", tx_frame, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    reset_L = 1'b1;
    step();

    // Single word on channel 2: latency and field placement.
    push(2, 10'h155, 1'b1);
    active = 1'b1; link_ready = 1'b1;
    step();
    chk("t1_rd", fifo_rd, 4'b0100);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_rd_off", fifo_rd, 0);
    chk("t1_valid_early", tx_valid, 0);
    step();
    chk("t1_valid", tx_valid, 1);
    chk("t1_data", tx_frame[9:0], 10'h155);
    chk("t1_ch", tx_frame[11:10], 2);
    chk("t1_seq", tx_frame[15:12], 0);
    chk("t1_cnt_pre", frame_cnt, 0);
    step();
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_valid_off", tx_valid, 0);
    chk("t1_idle", busy, 0);

    // All four FIFOs with 3 words: strict 0,1,2,3 order at 4 cycles per frame.
    apply_reset();
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < 4; ch++)
        push(ch, word_t'(ch * 16 + k + 1), 1'b1);
    active = 1'b1; link_ready = 1'b1;
    run_until_cnt(8'd12, 100, n);
    chk("t2_period", n, 48);
    chk("t2_empty", fifo_empty, 4'hF);
    chk("t2_sb_drained", exp_q.size(), 0);
    for (int k = 0; k < 5; k++) push(0, word_t'(10'h200 + k), 1'b1);
    run_until_cnt(8'd17, 60, n);
    chk("t2_wrap_drained", exp_q.size(), 0);

    // Back-pressure: frame held stable, no further pops.
    link_ready = 1'b0;
    push(1, 10'h2AA, 1'b1);
    wait_valid(10);
    held = tx_frame;
    chk("t3_ch", held[11:10], 1);
    push(2, 10'h0F0, 1'b1);
    repeat (10) begin
      step();
      chk("t3_valid_hold", tx_valid, 1);
      chk("t3_frame_hold", tx_frame, held);
      chk("t3_no_rd", fifo_rd, 0);
    end
    link_ready = 1'b1;
    step();
    chk("t3_idle", busy, 0);
    chk("t3_cnt", frame_cnt, 18);
    run_until_cnt(8'd19, 20, n);

    // active low: no pops; dropping active in SEND still completes the frame.
    active = 1'b0;
    push(3, 10'h111, 1'b1);
    repeat (8) begin
      step();
      chk("t4_no_rd", fifo_rd, 0);
      chk("t4_not_busy", busy, 0);
    end
    active = 1'b1; link_ready = 1'b0;
    wait_valid(10);
    active = 1'b0;
    push(0, 10'h0AB, 1'b0);
    link_ready = 1'b1;
    step();
    chk("t4_cnt", frame_cnt, 20);
    repeat (8) begin
      step();
      chk("t4_no_rd_after", fifo_rd, 0);
      chk("t4_idle_after", busy, 0);
    end

    // Reset during SEND drops the frame and restarts at channel 0, seq 0.
    link_ready = 1'b0; active = 1'b1;
    wait_valid(10);
    reset_L = 1'b0;
    #1;
    chk("t5_valid", tx_valid, 0);
    chk("t5_rd", fifo_rd, 0);
    chk("t5_cnt", frame_cnt, 0);
    chk("t5_frame", tx_frame, 0);
    chk("t5_busy", busy, 0);
    step();
    step();
    reset_L = 1'b1;
    exp_seq = '0;
    push(0, 10'h0C3, 1'b1);
    push(2, 10'h1E1, 1'b1);
    link_ready = 1'b1;
    run_until_cnt(8'd2, 20, n);
    chk("t5_sb_drained", exp_q.size(), 0);

    // Parity on an all-ones word from channel 1 at seq 0.
    apply_reset();
    push(1, 10'h3FF, 1'b1);
    active = 1'b1; link_ready = 1'b0;
    wait_valid(10);
`ifdef LINK_PARITY_EN
    chk("t6_parity", tx_frame[16], 1);
`else
    chk("t6_parity", tx_frame[16], 0);
`endif
    chk("t6_ch", tx_frame[11:10], 1);
    link_ready = 1'b1;
    step();
    chk("t6_cnt", frame_cnt, 1);

    chk("end_sb_empty", exp_q.size(), 0);
    chk("end_underflow", underflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dl_tx_scheduler.md
# dl_tx_scheduler

Downstream consumer of the transaction layer's four output FIFOs. It drains them round-robin, one word per frame, and tags each word with its channel, a sequence number and a parity bit. It then presents the frame to the data-link transmitter through a valid/ready handshake. It pops a FIFO only when that FIFO is non-empty, the transaction layer reports active, and no frame is in flight.

## Interface
Parameters:
- WORD_SIZE, 10, width of each FIFO data word
- SEQ_W, 4, sequence-number width; wraps modulo 2^SEQ_W
- FIFO_UNITS, 4, number of output FIFOs drained (fixed at 4; channel tag is 2 bits)

Ports:
- clk  input  1  single clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- active  input  1  transaction-layer state machine active indication
- fifo_empty  input  4  empty flags of output FIFOs 0..3
- fifo_data0..fifo_data3  input  WORD_SIZE each  read data of output FIFOs 0..3
- link_ready  input  1  downstream accepts the frame this cycle
- fifo_rd  output  4  one-hot pop strobes to output FIFOs 0..3
- tx_frame  output  WORD_SIZE+SEQ_W+3  {parity, seq, ch[1:0], data}
- tx_valid  output  1  tx_frame holds a frame
- frame_cnt  output  8  frames accepted since reset; wraps 255→0
- busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, POP, CAPT, SEND.
- IDLE:
  - If active=1 and any fifo_empty bit is 0, pick grant as the first non-empty channel searching from (last_grant+1) mod 4 upward, register it, and go to POP.
  - Otherwise stay in IDLE.
- POP: fifo_rd[grant]=1 for exactly this cycle, then go to CAPT.
- CAPT: FIFO read data is valid in the cycle after the pop. Load tx_frame with {parity, seq, grant, fifo_data[grant]}, set tx_valid=1, go to SEND.
- SEND:
  - Hold tx_frame and tx_valid stable until tx_valid & link_ready.
  - On that cycle: tx_valid→0, seq++, frame_cnt++, last_grant←grant, go to IDLE.
- active is sampled only in IDLE. Deasserting it mid-frame does not abort; the frame completes.
- fifo_empty is sampled only in IDLE. The granted FIFO cannot become empty before POP because only this block pops it.
- Round-robin is starvation-free: with all four channels non-empty, the grant order is 0,1,2,3,0…
- fifo_rd is never multi-hot and never asserted outside POP.

## Timing
- Reset values:
  - State IDLE; fifo_rd=0; tx_frame=0; tx_valid=0; frame_cnt=0; busy=0.
  - seq=0; last_grant=3, so the first grant searches from channel 0.
- Asynchronous reset in any state returns all of the above immediately. An in-flight frame is dropped and is not counted.
- Latency: a non-empty FIFO with active=1 in IDLE at cycle N gives fifo_rd at N+1 and tx_valid at N+3.
- Minimum frame period is 4 cycles (IDLE, POP, CAPT, SEND with link_ready=1).
- link_ready may be high before tx_valid. Only a cycle with both high is a handshake.
- seq wraps from 2^SEQ_W−1 to 0 with no flag.

## Configuration
- LINK_PARITY_EN defined: tx_frame MSB is the even parity (XOR) of all lower tx_frame bits, computed at CAPT.
- LINK_PARITY_EN undefined: the MSB is tied to 0. Frame width and all timing are unchanged.

## Test plan
- Reset, then load FIFO 2 with 0x155, active=1, link_ready=1 → fifo_rd=4'b0100 for one cycle; 2 cycles later tx_frame data=0x155, ch=2, seq=0; frame_cnt=1 after the handshake.
- All four FIFOs hold 3 words each, link_ready=1 → grant sequence 0,1,2,3,0,1,2,3,0,1,2,3; seq 0..11 wraps to 0 after 15; frame_cnt=12; all FIFOs end empty.
- Hold link_ready=0 for 10 cycles with a frame pending → tx_valid=1 and tx_frame stable all 10 cycles, no further fifo_rd; raise link_ready → one handshake, return to IDLE.
- active=0 with non-empty FIFOs → no fifo_rd and busy=0; drop active during SEND → that frame still completes and no new pop follows.
- Assert reset_L=0 during SEND → tx_valid, fifo_rd, frame_cnt and seq are 0 in the same cycle; after release, the next frame is taken from channel 0 with seq=0.
- LINK_PARITY_EN build, data=0x3FF, ch=1, seq=0 → parity bit 1; non-EN build → parity bit 0.
